// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: ALUOp and func codes, forwarding selects,
// the decoded ALU operation and the multiplier sequencer states.
package pipe_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNC_ADD   = 6'h20;
  localparam logic [5:0] FUNC_SUB   = 6'h22;
  localparam logic [5:0] FUNC_AND   = 6'h24;
  localparam logic [5:0] FUNC_OR    = 6'h25;
  localparam logic [5:0] FUNC_SLT   = 6'h2A;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_SLT, ALU_MULTU, ALU_MFHI, ALU_MFLO
  } alu_op_e;

  typedef enum logic {MUL_IDLE, MUL_RUN} mul_state_e;

  function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [5:0] func);
    alu_op_e op;
    op = ALU_NOP;
    case (aluop)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_OR:  op = ALU_OR;
      default: begin
        case (func)
          FUNC_ADD:   op = ALU_ADD;
          FUNC_SUB:   op = ALU_SUB;
          FUNC_AND:   op = ALU_AND;
          FUNC_OR:    op = ALU_OR;
          FUNC_SLT:   op = ALU_SLT;
          FUNC_MULTU: op = ALU_MULTU;
          FUNC_MFHI:  op = ALU_MFHI;
          FUNC_MFLO:  op = ALU_MFLO;
          default:    op = ALU_NOP;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_multu_seq.sv
// Sequential unsigned shift-add multiplier. product presents the result of
// the current iteration so the final value is valid in the same cycle as done.
module ex_multu_seq
  import pipe_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_CYC = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(MUL_CYC);

  mul_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     mcand;
  logic [2*W-1:0]   prod_q;
  logic [W:0]       sum;

  // {acc, mplr}: add multiplicand into acc when mplr LSB is set, then shift right.
  always_comb begin
    sum     = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand} : '0);
    product = {sum, prod_q[W-1:1]};
  end

  always_comb begin
    state_n = state;
    case (state)
      MUL_IDLE: if (start) state_n = MUL_RUN;
      MUL_RUN:  if (done)  state_n = MUL_IDLE;
      default:  state_n = MUL_IDLE;
    endcase
  end

  assign busy = (state == MUL_RUN);
  assign done = (state == MUL_RUN) && (cnt == CNT_W'(MUL_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      prod_q <= '0;
    end else begin
      state <= state_n;
      if (state == MUL_IDLE && start) begin
        mcand  <= a;
        prod_q <= {{W{1'b0}}, b};
        cnt    <= '0;
      end else if (state == MUL_RUN) begin
        prod_q <= product;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding/ALUSrc/RegDst muxes, ALU, branch target, the
// EX/MEM pipeline register and the HI/LO multiplier with upstream stall.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_CYC = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  nextpc_ex,
  input  logic [4:0]    rs_ex,
  input  logic [4:0]    rt_ex,
  input  logic [4:0]    rd_ex,
  input  logic [5:0]    func_ex,
  input  logic [W-1:0]  rd1_ex,
  input  logic [W-1:0]  rd2_ex,
  input  logic [W-1:0]  imm_ex,
  input  logic          regdst_ex,
  input  logic          alusrc_ex,
  input  logic [1:0]    aluop_ex,
  input  logic [1:0]    memrw_ex,
  input  logic          branch_ex,
  input  logic [1:0]    wb_ex,
  input  logic [1:0]    fwd_a,
  input  logic [1:0]    fwd_b,
  input  logic [W-1:0]  wb_data_wb,
  output logic          stall_o,
  output logic [W-1:0]  alu_result_mem,
  output logic [W-1:0]  wdata_mem,
  output logic [4:0]    wreg_mem,
  output logic          zero_mem,
  output logic [W-1:0]  btarget_mem,
  output logic [1:0]    memrw_mem,
  output logic [1:0]    wb_mem,
  output logic          branch_mem,
  output logic [W-1:0]  hi_o,
  output logic [W-1:0]  lo_o
);

  alu_op_e        alu_op;
  logic [W-1:0]   op_a, b_fwd, op_b, result, btarget;
  logic [4:0]     wreg;
  logic           is_multu, mul_busy, mul_done;
  logic [2*W-1:0] mul_product;

  always_comb begin
    case (fwd_a)
      FWD_WB:  op_a = wb_data_wb;
      FWD_MEM: op_a = alu_result_mem;
      default: op_a = rd1_ex;
    endcase
    case (fwd_b)
      FWD_WB:  b_fwd = wb_data_wb;
      FWD_MEM: b_fwd = alu_result_mem;
      default: b_fwd = rd2_ex;
    endcase
  end

  assign op_b     = alusrc_ex ? imm_ex : b_fwd;
  assign wreg     = regdst_ex ? rd_ex : rt_ex;
  assign alu_op   = alu_decode(aluop_ex, func_ex);
  assign is_multu = (alu_op == ALU_MULTU);
  assign stall_o  = is_multu && !mul_done;
  assign btarget  = nextpc_ex + {imm_ex[W-3:0], 2'b00};

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_SLT:  result = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_MFHI: result = hi_o;
      ALU_MFLO: result = lo_o;
      default:  result = '0;
    endcase
  end

  ex_multu_seq #(.W(W), .MUL_CYC(MUL_CYC)) u_multu (
    .clk     (clk),
    .reset   (reset),
    .start   (is_multu && !mul_busy),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (mul_done) begin
      {hi_o, lo_o} <= mul_product;
    end
  end

  // A stalled multu stays in EX, so EX/MEM receives bubbles until its final cycle.
  always_ff @(posedge clk) begin
    if (reset || stall_o) begin
      alu_result_mem <= '0;
      wdata_mem      <= '0;
      wreg_mem       <= '0;
      zero_mem       <= 1'b0;
      btarget_mem    <= '0;
      memrw_mem      <= '0;
      wb_mem         <= '0;
      branch_mem     <= 1'b0;
    end else begin
      alu_result_mem <= result;
      wdata_mem      <= b_fwd;
      wreg_mem       <= wreg;
      zero_mem       <= (result == '0);
      btarget_mem    <= btarget;
      memrw_mem      <= memrw_ex;
      wb_mem         <= wb_ex;
      branch_mem     <= branch_ex;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver issues directed vectors on the falling
// edge and queues expected EX/MEM contents; a monitor checks after each rising edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nextpc_ex, rd1_ex, rd2_ex, imm_ex, wb_data_wb;
  logic [4:0]  rs_ex, rt_ex, rd_ex;
  logic [5:0]  func_ex;
  logic        regdst_ex, alusrc_ex, branch_ex;
  logic [1:0]  aluop_ex, memrw_ex, wb_ex, fwd_a, fwd_b;
  logic        stall_o, zero_mem, branch_mem;
  logic [31:0] alu_result_mem, wdata_mem, btarget_mem, hi_o, lo_o;
  logic [4:0]  wreg_mem;
  logic [1:0]  memrw_mem, wb_mem;

  always #5 clk = ~clk;

  ex_stage #(.W(32), .MUL_CYC(32)) dut (
    .clk(clk), .reset(reset), .nextpc_ex(nextpc_ex), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .rd_ex(rd_ex), .func_ex(func_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .imm_ex(imm_ex),
    .regdst_ex(regdst_ex), .alusrc_ex(alusrc_ex), .aluop_ex(aluop_ex), .memrw_ex(memrw_ex),
    .branch_ex(branch_ex), .wb_ex(wb_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wb_data_wb(wb_data_wb), .stall_o(stall_o), .alu_result_mem(alu_result_mem),
    .wdata_mem(wdata_mem), .wreg_mem(wreg_mem), .zero_mem(zero_mem),
    .btarget_mem(btarget_mem), .memrw_mem(memrw_mem), .wb_mem(wb_mem),
    .branch_mem(branch_mem), .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    string       name;
    logic [31:0] alu, btarget, wdata, hi, lo;
    logic [4:0]  wreg;
    logic [5:0]  ctrl;  // {zero, branch, memrw, wb}
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [31:0] alu, input logic [4:0] wreg,
                              input logic zero, input logic br, input logic [1:0] mrw,
                              input logic [1:0] wb, input logic [31:0] bt, input logic [31:0] wd);
    exp_t e;
    e.name = nm; e.alu = alu; e.wreg = wreg; e.ctrl = {zero, br, mrw, wb};
    e.btarget = bt; e.wdata = wd; e.hi = exp_hi; e.lo = exp_lo;
    return e;
  endfunction

  task automatic idle();
    reset = 1'b0; nextpc_ex = '0; rd1_ex = '0; rd2_ex = '0; imm_ex = '0; wb_data_wb = '0;
    rs_ex = '0; rt_ex = '0; rd_ex = '0; func_ex = '0; regdst_ex = 1'b0; alusrc_ex = 1'b0;
    branch_ex = 1'b0; aluop_ex = '0; memrw_ex = '0; wb_ex = '0; fwd_a = '0; fwd_b = '0;
  endtask

  task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    idle();
    aluop_ex = 2'b10; func_ex = f; rd1_ex = a; rd2_ex = b; regdst_ex = 1'b1; rd_ex = rd;
    rt_ex = 5'd31; wb_ex = 2'b01;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".alu"},  alu_result_mem, e.alu);
        chk({e.name, ".wreg"}, {27'd0, wreg_mem}, {27'd0, e.wreg});
        chk({e.name, ".ctrl"}, {26'd0, zero_mem, branch_mem, memrw_mem, wb_mem}, {26'd0, e.ctrl});
        chk({e.name, ".btgt"}, btarget_mem, e.btarget);
        chk({e.name, ".wdata"}, wdata_mem, e.wdata);
        chk({e.name, ".hi"}, hi_o, e.hi);
        chk({e.name, ".lo"}, lo_o, e.lo);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  // Driver
  initial begin
    idle();
    @(negedge clk); reset = 1'b1; sb.push_back(mk("reset", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    @(negedge clk); reset = 1'b1; sb.push_back(mk("reset2", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    #1 chk("reset.stall", {31'd0, stall_o}, 32'd0);

    rtype(6'h20, 32'd5, 32'd7, 5'd3);
    sb.push_back(mk("add", 32'd12, 5'd3, 0, 0, 2'b00, 2'b01, 0, 32'd7));

    rtype(6'h20, 32'd8, 32'd8, 5'd4);
    sb.push_back(mk("add16", 32'h10, 5'd4, 0, 0, 2'b00, 2'b01, 0, 32'd8));

    @(negedge clk); idle();
    fwd_a = 2'b10; rd1_ex = 32'h999; rd2_ex = 32'd1; aluop_ex = 2'b01; rt_ex = 5'd6;
    sb.push_back(mk("fwd_mem_sub", 32'h0F, 5'd6, 0, 0, 2'b00, 2'b00, 0, 32'd1));

    @(negedge clk); idle();
    fwd_b = 2'b01; wb_data_wb = 32'd9; rd1_ex = 32'd6; rd2_ex = 32'h70; aluop_ex = 2'b11; rt_ex = 5'd7;
    sb.push_back(mk("fwd_wb_or", 32'h0F, 5'd7, 0, 0, 2'b00, 2'b00, 0, 32'd9));

    @(negedge clk); idle();
    fwd_a = 2'b11; fwd_b = 2'b11; rd1_ex = 32'd3; rd2_ex = 32'd4; wb_data_wb = 32'd100;
    sb.push_back(mk("fwd11_reg", 32'd7, 5'd0, 0, 0, 2'b00, 2'b00, 0, 32'd4));

    @(negedge clk); idle();
    rd1_ex = 32'h100; imm_ex = 32'hFFFF_FFFC; alusrc_ex = 1'b1; memrw_ex = 2'b10;
    rt_ex = 5'd8; rd_ex = 5'd9; rd2_ex = 32'h77; wb_ex = 2'b11;
    sb.push_back(mk("lw", 32'hFC, 5'd8, 0, 0, 2'b10, 2'b11, 32'hFFFF_FFF0, 32'h77));

    @(negedge clk); idle();
    rd1_ex = 32'h55; rd2_ex = 32'h55; aluop_ex = 2'b01; nextpc_ex = 32'h40; imm_ex = 32'd3;
    branch_ex = 1'b1; rt_ex = 5'd2;
    sb.push_back(mk("beq", 32'd0, 5'd2, 1, 1, 2'b00, 2'b00, 32'h4C, 32'h55));

    rtype(6'h24, 32'hF0F0, 32'hFF00, 5'd10);
    sb.push_back(mk("and", 32'hF000, 5'd10, 0, 0, 2'b00, 2'b01, 0, 32'hFF00));
    rtype(6'h2A, 32'h8000_0000, 32'd1, 5'd11);
    sb.push_back(mk("slt_neg", 32'd1, 5'd11, 0, 0, 2'b00, 2'b01, 0, 32'd1));
    rtype(6'h2A, 32'd1, 32'h8000_0000, 5'd12);
    sb.push_back(mk("slt_pos", 32'd0, 5'd12, 1, 0, 2'b00, 2'b01, 0, 32'h8000_0000));
    rtype(6'h22, 32'd0, 32'd1, 5'd13);
    sb.push_back(mk("sub_wrap", 32'hFFFF_FFFF, 5'd13, 0, 0, 2'b00, 2'b01, 0, 32'd1));
    rtype(6'h3F, 32'd5, 32'd7, 5'd14);
    sb.push_back(mk("bad_func", 32'd0, 5'd14, 1, 0, 2'b00, 2'b01, 0, 32'd7));

    // multu 0xFFFFFFFF * 2, held in EX while stall_o is high
    for (int i = 0; i < 33; i++) begin
      rtype(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd5);
      wb_ex = 2'b00;
      #1 chk($sformatf("multu.stall%0d", i), {31'd0, stall_o}, {31'd0, (i < 32)});
      if (i < 32) begin
        sb.push_back(mk("multu_bubble", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      end else begin
        exp_hi = 32'd1; exp_lo = 32'hFFFF_FFFE;
        sb.push_back(mk("multu_exit", 0, 5'd5, 1, 0, 2'b00, 2'b00, 0, 32'd2));
      end
    end
    rtype(6'h10, 32'd0, 32'd0, 5'd2);
    sb.push_back(mk("mfhi", 32'd1, 5'd2, 0, 0, 2'b00, 2'b01, 0, 32'd0));
    rtype(6'h12, 32'd0, 32'd0, 5'd3);
    sb.push_back(mk("mflo", 32'hFFFF_FFFE, 5'd3, 0, 0, 2'b00, 2'b01, 0, 32'd0));

    // multu 3*5 aborted by reset while cnt == 10
    for (int i = 0; i < 11; i++) begin
      rtype(6'h19, 32'd3, 32'd5, 5'd5);
      wb_ex = 2'b00;
      #1 chk($sformatf("multu2.stall%0d", i), {31'd0, stall_o}, 32'd1);
      sb.push_back(mk("multu2_bubble", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    end
    rtype(6'h19, 32'd3, 32'd5, 5'd5);
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    sb.push_back(mk("abort_reset", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

    rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd9);
    #1 chk("post_reset.stall", {31'd0, stall_o}, 32'd0);
    sb.push_back(mk("slt_after_reset", 32'd1, 5'd9, 0, 0, 2'b00, 2'b01, 0, 32'd1));
    rtype(6'h10, 32'd0, 32'd0, 5'd4);
    sb.push_back(mk("mfhi_cleared", 32'd0, 5'd4, 1, 0, 2'b00, 2'b01, 0, 32'd0));

    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
